rgbw_frame_sched: RTL and testbench

Frame-level scheduler that shares the RGBW serial-output FIFO write port between two pixel sources (A and B). Grants exclusive ownership to one source per frame with round-robin fairness and forwards its 32-bit pixel words into the FIFO. Terminates every frame with a stream-reset word, inserting one itself on overflow, timeout or request drop. Sits upstream of the FIFO that feeds the RGBW serial output engine.

---
 rtl/rgbw_frame_sched_if.sv | 29 ++
 rtl/rgbw_frame_sched.sv | 147 ++++++++++++++
 tb/tb_rgbw_frame_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgbw_frame_sched_if.sv
// rgbw_frame_sched_if: source handshakes and FIFO write port of the RGBW frame scheduler.
// master = scheduler side, slave = sources/FIFO side.
interface rgbw_frame_sched_if;
   localparam int unsigned WORD_W = 32;

   logic              a_req;
   logic              a_valid;
   logic [WORD_W-1:0] a_data;
   logic              a_ready;
   logic              b_req;
   logic              b_valid;
   logic [WORD_W-1:0] b_data;
   logic              b_ready;
   logic              in_wr_fifo_afull;
   logic              out_wr_fifo_en;
   logic [WORD_W-1:0] out_wr_fifo_data;
   logic [1:0]        out_owner;
   logic              out_frame_done;

   modport master (
      input  a_req, a_valid, a_data, b_req, b_valid, b_data, in_wr_fifo_afull,
      output a_ready, b_ready, out_wr_fifo_en, out_wr_fifo_data, out_owner, out_frame_done
   );

   modport slave (
      output a_req, a_valid, a_data, b_req, b_valid, b_data, in_wr_fifo_afull,
      input  a_ready, b_ready, out_wr_fifo_en, out_wr_fifo_data, out_owner, out_frame_done
   );
endinterface

// File: rtl/rgbw_frame_sched.sv
// rgbw_frame_sched: per-frame round-robin owner of the RGBW FIFO write port (sources A/B).
// Define RGBW_SCHED_TIMEOUT_EN to compile in the owner-idle timeout with forced stream reset.
module rgbw_frame_sched #(
   parameter int unsigned MAX_PIXELS   = 1024,
   parameter int unsigned TIMEOUT_CLKS = 9600
) (
   input logic                clk,
   input logic                rst,
   rgbw_frame_sched_if.master bus
);
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned PIX_W    = $clog2(MAX_PIXELS + 1);
   localparam logic [WORD_W-1:0] RST_WORD = 32'hC000_0000;

   typedef enum logic [2:0] {IDLE, GRANT, PASS, INS_RST, RELEASE} state_t;

   state_t            state, state_n;
   logic              sel, sel_n;     // 0 = A, 1 = B
   logic              last, last_n;   // source served most recently
   logic [PIX_W-1:0]  pix_cnt, pix_n;
   logic              wr_en, wr_en_n;
   logic [WORD_W-1:0] wr_data, wr_data_n;
   logic [1:0]        owner, owner_n;
   logic              done, done_n;
   logic              own_req, own_valid, accept, timeout_hit;
   logic [WORD_W-1:0] own_data;

`ifdef RGBW_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TO_W-1:0] to_cnt, to_n;
`else
   // No timeout hardware in this build; the parameter stays for a uniform instantiation.
   if (TIMEOUT_CLKS == 0) begin : g_timeout_unused
   end
`endif

   assign own_req   = sel ? bus.b_req   : bus.a_req;
   assign own_valid = sel ? bus.b_valid : bus.a_valid;
   assign own_data  = sel ? bus.b_data  : bus.a_data;

   // afull already accounts for the one write sitting in the output register
   assign bus.a_ready = (state == PASS) && !sel && !bus.in_wr_fifo_afull;
   assign bus.b_ready = (state == PASS) &&  sel && !bus.in_wr_fifo_afull;
   assign accept      = (state == PASS) && own_valid && !bus.in_wr_fifo_afull;

   assign bus.out_wr_fifo_en   = wr_en;
   assign bus.out_wr_fifo_data = wr_data;
   assign bus.out_owner        = owner;
   assign bus.out_frame_done   = done;

   always_comb begin
      state_n     = state;
      sel_n       = sel;
      last_n      = last;
      pix_n       = pix_cnt;
      wr_en_n     = 1'b0;
      wr_data_n   = wr_data;
      owner_n     = owner;
      done_n      = 1'b0;
      timeout_hit = 1'b0;
`ifdef RGBW_SCHED_TIMEOUT_EN
      to_n        = to_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               sel_n   = (bus.a_req && bus.b_req) ? !last : bus.b_req;
               owner_n = sel_n ? 2'd2 : 2'd1;
               state_n = GRANT;
            end
         end
         GRANT: begin
            pix_n   = '0;
`ifdef RGBW_SCHED_TIMEOUT_EN
            to_n    = '0;
`endif
            state_n = PASS;
         end
         PASS: begin
`ifdef RGBW_SCHED_TIMEOUT_EN
            if (accept) begin
               to_n = '0;
            end else begin
               to_n        = to_cnt + TO_W'(1);
               timeout_hit = (to_n == TO_W'(TIMEOUT_CLKS));
            end
`endif
            // words with bit31 clear are consumed but never reach the FIFO
            if (accept && own_data[31]) begin
               wr_en_n   = 1'b1;
               wr_data_n = own_data;
               if (!own_data[30]) pix_n = pix_cnt + PIX_W'(1);
            end
            if (accept && own_data[31] && own_data[30]) begin
               state_n = RELEASE;
               done_n  = 1'b1;
               owner_n = 2'd0;
               last_n  = sel;
            end else if ((pix_n == PIX_W'(MAX_PIXELS)) || !own_req || timeout_hit) begin
               state_n = INS_RST;
            end
         end
         INS_RST: begin
            if (!bus.in_wr_fifo_afull) begin
               wr_en_n   = 1'b1;
               wr_data_n = RST_WORD;
               state_n   = RELEASE;
               done_n    = 1'b1;
               owner_n   = 2'd0;
               last_n    = sel;
            end
         end
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= 1'b0;
         last    <= 1'b1;
         pix_cnt <= '0;
         wr_en   <= 1'b0;
         wr_data <= '0;
         owner   <= 2'd0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         sel     <= sel_n;
         last    <= last_n;
         pix_cnt <= pix_n;
         wr_en   <= wr_en_n;
         wr_data <= wr_data_n;
         owner   <= owner_n;
         done    <= done_n;
      end
   end

`ifdef RGBW_SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) to_cnt <= '0;
      else     to_cnt <= to_n;
   end
`endif

endmodule

// File: tb/tb_rgbw_frame_sched.sv
// tb_rgbw_frame_sched: directed self-checking bench for rgbw_frame_sched (MAX_PIXELS=4, TIMEOUT_CLKS=20).
// Honours RGBW_SCHED_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_rgbw_frame_sched;
   localparam logic [31:0] RST_WORD = 32'hC000_0000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   done_cnt;
   logic [31:0] wq[$];

   rgbw_frame_sched_if bif();

   rgbw_frame_sched #(.MAX_PIXELS(4), .TIMEOUT_CLKS(20)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO-side observer
   always @(negedge clk) begin
      if (bif.out_wr_fifo_en === 1'b1) wq.push_back(bif.out_wr_fifo_data);
      if (bif.out_frame_done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one word and hold it until accepted
   task automatic send(input bit src, input logic [31:0] w);
      int n = 0;
      bit ok = 1'b0;
      if (src) begin bif.b_valid = 1'b1; bif.b_data = w; end
      else     begin bif.a_valid = 1'b1; bif.a_data = w; end
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = src ? (bif.b_ready === 1'b1) : (bif.a_ready === 1'b1);
         tick();
         n++;
      end
      bif.a_valid = 1'b0;
      bif.b_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_accept src=%0d word=%h not accepted within 50 cycles", src, w);
      end
   endtask

   task automatic wait_owner(input logic [1:0] exp, input int budget);
      int n = 0;
      while (bif.out_owner !== exp && n < budget) begin tick(); n++; end
      checks++;
      if (bif.out_owner !== exp) begin
         failures++;
         $display("FAIL wait_owner got=%0d exp=%0d", bif.out_owner, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({bif.out_wr_fifo_en, bif.out_owner, bif.out_frame_done, bif.a_ready, bif.b_ready} !== 6'b0 ||
          bif.out_wr_fifo_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got en=%b owner=%0d done=%b ar=%b br=%b data=%h exp all 0",
                  bif.out_wr_fifo_en, bif.out_owner, bif.out_frame_done, bif.a_ready, bif.b_ready,
                  bif.out_wr_fifo_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_a_only();
      logic [31:0] exp [4] = '{32'h8011_2233, 32'h8044_5566, 32'h8077_8899, RST_WORD};
      int d0;
      wq.delete();
      d0 = done_cnt;
      bif.a_req = 1'b1;
      tick();
      checks++;
      if (bif.out_owner !== 2'd1) begin
         failures++; $display("FAIL a_only_grant got=%0d exp=1", bif.out_owner);
      end
      send(1'b0, exp[0]);
      checks++;
      if (bif.out_wr_fifo_en !== 1'b1 || bif.out_wr_fifo_data !== exp[0]) begin
         failures++;
         $display("FAIL a_only_latency got en=%b data=%h exp en=1 data=%h",
                  bif.out_wr_fifo_en, bif.out_wr_fifo_data, exp[0]);
      end
      send(1'b0, exp[1]);
      send(1'b0, exp[2]);
      send(1'b0, exp[3]);
      bif.a_req = 1'b0;
      checks++;
      if (bif.out_frame_done !== 1'b1 || bif.out_owner !== 2'd0) begin
         failures++;
         $display("FAIL a_only_release got done=%b owner=%0d exp done=1 owner=0",
                  bif.out_frame_done, bif.out_owner);
      end
      tick();
      checks++;
      if (bif.out_frame_done !== 1'b0) begin
         failures++; $display("FAIL a_only_done_width got=%b exp=0", bif.out_frame_done);
      end
      tick(); tick();
      checks++;
      if (wq.size() != 4 || done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL a_only_counts got writes=%0d dones=%0d exp writes=4 dones=1", wq.size(), done_cnt - d0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL a_only_word%0d got=%h exp=%h", i, (i < wq.size()) ? wq[i] : 32'hx, exp[i]);
         end
      end
   endtask

   task automatic test_tie();
      int d0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wq.delete();
      d0 = done_cnt;
      bif.a_req = 1'b1;
      bif.b_req = 1'b1;
      tick();
      checks++;
      if (bif.out_owner !== 2'd1) begin
         failures++; $display("FAIL tie_first got=%0d exp=1", bif.out_owner);
      end
      send(1'b0, RST_WORD);
      wait_owner(2'd2, 10);
      send(1'b1, RST_WORD);
      wait_owner(2'd1, 10);
      send(1'b0, RST_WORD);
      bif.a_req = 1'b0;
      bif.b_req = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (wq.size() != 3 || done_cnt - d0 != 3 || bif.out_owner !== 2'd0) begin
         failures++;
         $display("FAIL tie_counts got writes=%0d dones=%0d owner=%0d exp writes=3 dones=3 owner=0",
                  wq.size(), done_cnt - d0, bif.out_owner);
      end
   endtask

   task automatic test_max_pixels();
      logic [31:0] exp [5] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0004, RST_WORD};
      int d0;
      wq.delete();
      d0 = done_cnt;
      bif.b_req = 1'b1;
      wait_owner(2'd2, 10);
      for (int i = 0; i < 4; i++) send(1'b1, exp[i]);
      bif.b_req   = 1'b0;
      bif.b_valid = 1'b1;
      bif.b_data  = 32'h8000_0005;
      checks++;
      if (bif.b_ready !== 1'b0) begin
         failures++; $display("FAIL max_ready_after_4th got=%b exp=0", bif.b_ready);
      end
      tick();
      bif.b_data = 32'h8000_0006;
      checks++;
      if (bif.out_wr_fifo_en !== 1'b1 || bif.out_wr_fifo_data !== RST_WORD ||
          bif.out_frame_done !== 1'b1 || bif.b_ready !== 1'b0) begin
         failures++;
         $display("FAIL max_insert got en=%b data=%h done=%b ready=%b exp en=1 data=%h done=1 ready=0",
                  bif.out_wr_fifo_en, bif.out_wr_fifo_data, bif.out_frame_done, bif.b_ready, RST_WORD);
      end
      tick();
      bif.b_valid = 1'b0;
      tick(); tick();
      checks++;
      if (wq.size() != 5 || done_cnt - d0 != 1) begin
         failures++;
         $display("FAIL max_counts got writes=%0d dones=%0d exp writes=5 dones=1", wq.size(), done_cnt - d0);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL max_word%0d got=%h exp=%h", i, (i < wq.size()) ? wq[i] : 32'hx, exp[i]);
         end
      end
   endtask

   task automatic test_afull();
      logic [31:0] exp [4] = '{32'h8001_0203, 32'h8004_0506, 32'h8007_0809, RST_WORD};
      int bad = 0;
      wq.delete();
      bif.a_req = 1'b1;
      wait_owner(2'd1, 10);
      send(1'b0, exp[0]);
      send(1'b0, exp[1]);
      bif.in_wr_fifo_afull = 1'b1;
      bif.a_valid = 1'b1;
      bif.a_data  = exp[2];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bif.a_ready !== 1'b0 || bif.b_ready !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL afull_ready got %0d cycles with ready=1 exp 0", bad);
      end
      bif.in_wr_fifo_afull = 1'b0;
      send(1'b0, exp[2]);
      send(1'b0, exp[3]);
      bif.a_req = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (wq.size() != 4) begin
         failures++; $display("FAIL afull_count got=%0d exp=4", wq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL afull_word%0d got=%h exp=%h", i, (i < wq.size()) ? wq[i] : 32'hx, exp[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      bit seen = 1'b0;
      wq.delete();
      bif.a_req = 1'b1;
      tick();
      checks++;
      if (bif.out_owner !== 2'd1) begin
         failures++; $display("FAIL timeout_grant got=%0d exp=1", bif.out_owner);
      end
`ifdef RGBW_SCHED_TIMEOUT_EN
      while (!seen && n < 60) begin
         tick();
         n++;
         if (bif.out_wr_fifo_en === 1'b1) seen = 1'b1;
      end
      bif.a_req = 1'b0;
      checks++;
      if (!seen || n != 22 || bif.out_wr_fifo_data !== RST_WORD || bif.out_frame_done !== 1'b1) begin
         failures++;
         $display("FAIL timeout_insert got seen=%b cycles=%0d data=%h done=%b exp seen=1 cycles=22 data=%h done=1",
                  seen, n, bif.out_wr_fifo_data, bif.out_frame_done, RST_WORD);
      end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bif.out_wr_fifo_en !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || bif.out_owner !== 2'd1) begin
         failures++;
         $display("FAIL no_timeout_hold got write=%b owner=%0d exp write=0 owner=1", seen, bif.out_owner);
      end
      bif.a_req = 1'b0;
      while (!seen && n < 10) begin
         tick();
         n++;
         if (bif.out_wr_fifo_en === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || bif.out_wr_fifo_data !== RST_WORD) begin
         failures++;
         $display("FAIL drop_insert got seen=%b data=%h exp seen=1 data=%h", seen, bif.out_wr_fifo_data, RST_WORD);
      end
`endif
      tick(); tick();
      checks++;
      if (wq.size() != 1 || bif.out_owner !== 2'd0) begin
         failures++;
         $display("FAIL timeout_counts got writes=%0d owner=%0d exp writes=1 owner=0", wq.size(), bif.out_owner);
      end
   endtask

   task automatic test_rst_mid();
      int d0;
      wq.delete();
      d0 = done_cnt;
      bif.a_req = 1'b1;
      wait_owner(2'd1, 10);
      tick();
      bif.a_valid = 1'b1;
      bif.a_data  = 32'h80AB_CDEF;
      rst = 1'b1;
      tick();
      checks++;
      if ({bif.out_wr_fifo_en, bif.out_owner, bif.out_frame_done, bif.a_ready, bif.b_ready} !== 6'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs got en=%b owner=%0d done=%b ar=%b br=%b exp all 0",
                  bif.out_wr_fifo_en, bif.out_owner, bif.out_frame_done, bif.a_ready, bif.b_ready);
      end
      rst = 1'b0;
      bif.a_valid = 1'b0;
      bif.a_req   = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (wq.size() != 0 || done_cnt != d0) begin
         failures++;
         $display("FAIL rst_mid_no_write got writes=%0d dones=%0d exp 0", wq.size(), done_cnt - d0);
      end
      bif.a_req = 1'b1;
      bif.b_req = 1'b1;
      tick();
      checks++;
      if (bif.out_owner !== 2'd1) begin
         failures++; $display("FAIL rst_mid_regrant got=%0d exp=1", bif.out_owner);
      end
      send(1'b0, RST_WORD);
      bif.a_req = 1'b0;
      bif.b_req = 1'b0;
      tick(); tick();
      checks++;
      if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== RST_WORD)) begin
         failures++;
         $display("FAIL rst_mid_after got writes=%0d first=%h exp writes=1 first=%h",
                  wq.size(), (wq.size() > 0) ? wq[0] : 32'hx, RST_WORD);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      rst      = 1'b1;
      bif.a_req = 1'b0; bif.a_valid = 1'b0; bif.a_data = '0;
      bif.b_req = 1'b0; bif.b_valid = 1'b0; bif.b_data = '0;
      bif.in_wr_fifo_afull = 1'b0;
      test_reset();
      test_a_only();
      test_tie();
      test_max_pixels();
      test_afull();
      test_timeout();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
